// File: rtl/avr_pkg.sv
// Shared types and constants for the AVR program loader.
package avr_pkg;

    localparam int         WORD_W   = 16;
    localparam logic [7:0] SYNC_DEF = 8'h55;

    typedef enum logic [2:0] {
        st_idle,
        st_len,
        st_lo,
        st_hi,
        st_csum,
        st_done,
        st_err
    } ldr_state_e;

endpackage

// File: rtl/avr_csum8.sv
// 8-bit running-sum accumulator; zero_next reports whether
// the sum would be zero after adding the current byte.
module avr_csum8 (
    input  logic       clk50,
    input  logic       reset,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic       zero_next
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    assign sum_d     = sum_q + din;
    assign zero_next = (sum_d == 8'h00);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (clr) begin
            sum_q <= 8'h00;
        end else if (add_en) begin
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/avr_prog_loader.sv
// Framed byte-stream loader for AVR program memory.
// Checksum byte and err are present only with AVR_LOADER_CSUM_EN.
module avr_prog_loader
    import avr_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    ldr_state_e state_q, state_d;

    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [7:0]        cnt_q;
    logic [7:0]        lo_q;
    logic              hold_q;
    logic              done_q;

    logic fire;
    logic sync_hit;
    logic start;
    logic len_ld;
    logic lo_ld;
    logic wr;
    logic fin_ok;

`ifdef AVR_LOADER_CSUM_EN
    logic fin_bad;
    logic sum_zero;
    logic csum_add;
    logic err_q;
`endif

    assign fire     = in_valid & ready_q;
    assign sync_hit = (in_data == SYNC_BYTE);

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        len_ld  = 1'b0;
        lo_ld   = 1'b0;
        wr      = 1'b0;
        fin_ok  = 1'b0;
`ifdef AVR_LOADER_CSUM_EN
        fin_bad = 1'b0;
`endif
        if (fire) begin
            unique case (state_q)
                st_idle, st_done, st_err: begin
                    if (sync_hit) begin
                        start   = 1'b1;
                        state_d = st_len;
                    end
                end
                st_len: begin
                    len_ld = 1'b1;
                    if (in_data != 8'h00) begin
                        state_d = st_lo;
                    end else begin
`ifdef AVR_LOADER_CSUM_EN
                        state_d = st_csum;
`else
                        state_d = st_done;
                        fin_ok  = 1'b1;
`endif
                    end
                end
                st_lo: begin
                    lo_ld   = 1'b1;
                    state_d = st_hi;
                end
                st_hi: begin
                    wr = 1'b1;
                    if (cnt_q == 8'd1) begin
`ifdef AVR_LOADER_CSUM_EN
                        state_d = st_csum;
`else
                        state_d = st_done;
                        fin_ok  = 1'b1;
`endif
                    end else begin
                        state_d = st_lo;
                    end
                end
`ifdef AVR_LOADER_CSUM_EN
                st_csum: begin
                    if (sum_zero) begin
                        state_d = st_done;
                        fin_ok  = 1'b1;
                    end else begin
                        state_d = st_err;
                        fin_bad = 1'b1;
                    end
                end
`endif
                default: state_d = st_idle;
            endcase
        end
    end

    // Address advances on the edge that retires the write strobe;
    // a new frame's sync takes priority and rewinds to 0.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 8'h00;
            lo_q    <= 8'h00;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            we_q    <= wr;
            if (wr) begin
                wdata_q <= {in_data, lo_q};
            end
            if (start) begin
                addr_q <= '0;
            end else if (we_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (len_ld) begin
                cnt_q <= in_data;
            end else if (wr) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (lo_ld) begin
                lo_q <= in_data;
            end
            if (start) begin
                hold_q <= 1'b1;
                done_q <= 1'b0;
            end else if (fin_ok) begin
                hold_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

`ifdef AVR_LOADER_CSUM_EN
    assign csum_add = fire && (state_q inside
                      {st_len, st_lo, st_hi, st_csum});

    avr_csum8 u_csum (
        .clk50     (clk50),
        .reset     (reset),
        .clr       (start),
        .add_en    (csum_add),
        .din       (in_data),
        .zero_next (sum_zero)
    );

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if (fin_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign core_hold = hold_q;
    assign done      = done_q;

endmodule

// File: tb/tb_avr_prog_loader.sv
// Directed bench for avr_prog_loader; follows AVR_LOADER_CSUM_EN.
module tb_avr_prog_loader;

    localparam int AW = 2;

    logic          clk50 = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          core_hold;
    logic          done;
    logic          err;

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;
    int rdy_drop = 0;

    logic [AW-1:0] la [64];
    logic [15:0]   ld [64];
    int            lc [64];
    int            nw = 0;

    avr_prog_loader #(.ADDR_W(AW), .SYNC_BYTE(8'h55)) dut (
        .clk50     (clk50),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk50 = ~clk50;

    always @(posedge clk50) cyc <= cyc + 1;

    always @(negedge clk50) begin
        if (mem_we === 1'b1 && nw < 64) begin
            la[nw] <= mem_addr;
            ld[nw] <= mem_wdata;
            lc[nw] <= cyc;
            nw     <= nw + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        if (in_ready !== 1'b1) rdy_drop++;
        @(posedge clk50);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic chk_wr(input int k,
                          input logic [AW-1:0] a,
                          input logic [15:0] d,
                          input int c);
        check("wr_addr", 32'(la[k]), 32'(a));
        check("wr_data", 32'(ld[k]), 32'(d));
        check("wr_cyc", lc[k], c);
    endtask

    initial begin
        int b;
        int c0;
        int c1;
        int cw [5];

        #12;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_hold", core_hold, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk50);
        reset = 1'b0;
        @(posedge clk50);
        #1;
        check("ready_up", in_ready, 1);

        // Two-word frame, bytes back to back
        b = nw;
        send(8'h55);
        check("sync_hold", core_hold, 1);
        send(8'h02);
        send(8'h0F);
        send(8'hE0);
        c0 = cyc;
        send(8'h01);
        check("mid_done", done, 0);
        send(8'h50);
        c1 = cyc;
`ifdef AVR_LOADER_CSUM_EN
        check("pre_csum_done", done, 0);
        send(8'hBE);
`endif
        check("a_done", done, 1);
        check("a_hold", core_hold, 0);
        check("a_err", err, 0);
        idle(3);
        check("a_nw", nw - b, 2);
        chk_wr(b, 0, 16'hE00F, c0);
        chk_wr(b + 1, 1, 16'h5001, c1);
        check("a_gap", c1 - c0, 2);
        check("a_we_low", mem_we, 0);
        check("a_addr_end", 32'(mem_addr), 2);
        check("a_ready", rdy_drop, 0);

`ifdef AVR_LOADER_CSUM_EN
        // Same frame with a bad checksum
        b = nw;
        send(8'h55);
        check("b_sync_done", done, 0);
        send(8'h02);
        send(8'h0F);
        send(8'hE0);
        send(8'h01);
        send(8'h50);
        send(8'hBF);
        check("b_err", err, 1);
        check("b_hold", core_hold, 1);
        check("b_done", done, 0);
        idle(3);
        check("b_nw", nw - b, 2);
        check("b_wd1", 32'(ld[b + 1]), 32'h5001);
`endif

        // Empty frame
        b = nw;
        send(8'h55);
        check("e_hold", core_hold, 1);
        check("e_err0", err, 0);
        send(8'h00);
`ifdef AVR_LOADER_CSUM_EN
        send(8'h00);
`endif
        check("e_done", done, 1);
        check("e_hold_lo", core_hold, 0);
        check("e_err", err, 0);
        idle(3);
        check("e_nw", nw - b, 0);

        // Garbage is dropped while in DONE
        send(8'h00);
        send(8'hAA);
        send(8'hFF);
        check("g_done", done, 1);
        check("g_hold", core_hold, 0);
        b = nw;
        send(8'h55);
        send(8'h01);
        send(8'h34);
        send(8'h12);
        c0 = cyc;
`ifdef AVR_LOADER_CSUM_EN
        check("g_pre_done", done, 0);
        send(8'hB9);
`endif
        check("g_done2", done, 1);
        check("g_err", err, 0);
        idle(3);
        check("g_nw", nw - b, 1);
        chk_wr(b, 0, 16'h1234, c0);

        // Five words into a four-word memory wrap to 0
        b = nw;
        send(8'h55);
        send(8'h05);
        for (int k = 1; k <= 5; k++) begin
            send(8'(k * 8'h11));
            send(8'(k * 8'h11));
            cw[k - 1] = cyc;
        end
`ifdef AVR_LOADER_CSUM_EN
        send(8'hFD);
`endif
        check("w_done", done, 1);
        idle(3);
        check("w_nw", nw - b, 5);
        chk_wr(b, 0, 16'h1111, cw[0]);
        chk_wr(b + 3, 3, 16'h4444, cw[3]);
        chk_wr(b + 4, 0, 16'h5555, cw[4]);

        // Reset between LO and HI of the second word
        b = nw;
        send(8'h55);
        send(8'h02);
        send(8'h0F);
        send(8'hE0);
        send(8'h01);
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        check("r_we", mem_we, 0);
        check("r_hold", core_hold, 1);
        check("r_ready", in_ready, 0);
        check("r_addr", 32'(mem_addr), 0);
        check("r_done", done, 0);
        check("r_err", err, 0);
        @(negedge clk50);
        reset = 1'b0;
        @(posedge clk50);
        #1;
        check("r_nw", nw - b, 1);
        b = nw;
        send(8'h50);
        check("r_idle_hold", core_hold, 1);
        send(8'h55);
        send(8'h01);
        send(8'h34);
        send(8'h12);
        c0 = cyc;
`ifdef AVR_LOADER_CSUM_EN
        send(8'hB9);
`endif
        check("r2_done", done, 1);
        idle(3);
        check("r2_nw", nw - b, 1);
        chk_wr(b, 0, 16'h1234, c0);
        check("r2_ready", rdy_drop, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
